// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared types for the operand fetch sequencer: RegisterFile commands, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package operand_fetch_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int IDX_W_DEF  = 5;
    localparam int TAG_W_DEF  = 16;
    localparam int STARVE_W   = 4;  // holds STARVE_LIMIT up to 15

    typedef enum logic [1:0] {
        RF_HOLD  = 2'b00,
        RF_READ1 = 2'b01,
        RF_READ2 = 2'b10,
        RF_WRITE = 2'b11
    } rf_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_OUT   = 2'b10
    } state_e;

    // One-source instructions only need latch 1; anything else reads both.
    function automatic rf_cmd_e read_cmd(input logic [1:0] num_src);
        return (num_src == 2'd1) ? RF_READ1 : RF_READ2;
    endfunction

endpackage

// File: rtl/operand_fetch_sequencer_if.sv
// Bundles decoder, writeback, RegisterFile and execute-side signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on instruction, writeback and operand channels.
interface operand_fetch_sequencer_if
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [IDX_W-1:0]  in_rs;
    logic [IDX_W-1:0]  in_rt;
    logic [1:0]        in_num_src;
    logic [TAG_W-1:0]  in_tag;

    logic              wb_valid;
    logic              wb_ready;
    logic [IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic [1:0]        rf_control;
    logic [DATA_W-1:0] rf_port_1;
    logic [DATA_W-1:0] rf_port_2;
    logic [DATA_W-1:0] rf_latch_1;
    logic [DATA_W-1:0] rf_latch_2;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op_a;
    logic [DATA_W-1:0] out_op_b;
    logic [TAG_W-1:0]  out_tag;

    // Sequencer side.
    modport master (
        input  in_valid, in_rs, in_rt, in_num_src, in_tag,
        output in_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rf_control, rf_port_1, rf_port_2,
        input  rf_latch_1, rf_latch_2,
        output out_valid, out_op_a, out_op_b, out_tag,
        input  out_ready
    );

    // Environment side: decoder, writeback source, RegisterFile, execute.
    modport slave (
        output in_valid, in_rs, in_rt, in_num_src, in_tag,
        input  in_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rf_control, rf_port_1, rf_port_2,
        output rf_latch_1, rf_latch_2,
        input  out_valid, out_op_a, out_op_b, out_tag,
        output out_ready
    );

endinterface

// File: rtl/operand_fetch_sequencer_wb_read_arbiter.sv
// Arbitrates the single RegisterFile port between writeback and the pending operand read.
// Latency: combinational grants; starve counter updates at the clock edge.
// Backpressure: writeback wins unless the read has lost STARVE_LIMIT ISSUE cycles in a row.
module wb_read_arbiter
    import operand_fetch_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic issue_req,
    input  logic wb_valid,
    output logic wb_ready,
    output logic wb_grant,
    output logic read_grant
);
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                force_read;

    // Grant selection and starve counter next value.
    always_comb begin
        force_read = issue_req && (starve_q == LIMIT);
        wb_ready   = !reset && !force_read;
        wb_grant   = wb_valid && wb_ready;
        read_grant = !reset && issue_req && !wb_grant;
        starve_d   = starve_q;
        if (reset || read_grant) begin
            starve_d = '0;
        end else if (issue_req && wb_grant) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Fetches up to two source operands from RegisterFile per instruction and owns its write port.
// Latency: 2 cycles accept-to-valid for 1/2 sources without contention, 1 cycle for 0 sources.
// Backpressure: in_ready only in IDLE; operands held stable in OUT until out_ready.
module operand_fetch_sequencer
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int TAG_W        = TAG_W_DEF,
    parameter int STARVE_LIMIT = 4
)(
    input  logic                      clk,
    input  logic                      reset,
    operand_fetch_sequencer_if.master bus
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] rs_q, rs_d;
    logic [IDX_W-1:0] rt_q, rt_d;
    logic [1:0]       nsrc_q, nsrc_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic issue_req;
    logic wb_grant;
    logic read_grant;

    assign issue_req = (state_q == ST_ISSUE);

    wb_read_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .issue_req  (issue_req),
        .wb_valid   (bus.wb_valid),
        .wb_ready   (bus.wb_ready),
        .wb_grant   (wb_grant),
        .read_grant (read_grant)
    );

    // Next state, held instruction fields, RegisterFile command and output muxing.
    always_comb begin
        state_d        = state_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        nsrc_d         = nsrc_q;
        tag_d          = tag_q;
        bus.in_ready   = 1'b0;
        bus.rf_control = RF_HOLD;
        bus.rf_port_1  = '0;
        bus.rf_port_2  = '0;
        bus.out_valid  = 1'b0;
        bus.out_op_a   = '0;
        bus.out_op_b   = '0;
        bus.out_tag    = '0;

        if (reset) begin
            state_d = ST_IDLE;
        end else begin
            // Writes never collide with reads: the arbiter only grants one.
            if (wb_grant) begin
                bus.rf_control = RF_WRITE;
                bus.rf_port_1  = bus.wb_data;
                bus.rf_port_2  = DATA_W'(bus.wb_rd);
            end

            unique case (state_q)
                ST_IDLE: begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        rs_d    = bus.in_rs;
                        rt_d    = bus.in_rt;
                        // A count of 3 behaves as 2 sources.
                        nsrc_d  = (bus.in_num_src == 2'd3) ? 2'd2 : bus.in_num_src;
                        tag_d   = bus.in_tag;
                        state_d = (bus.in_num_src == 2'd0) ? ST_OUT : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (read_grant) begin
                        bus.rf_control = read_cmd(nsrc_q);
                        bus.rf_port_1  = DATA_W'(rs_q);
                        bus.rf_port_2  = DATA_W'(rt_q);
                        state_d        = ST_OUT;
                    end
                end
                ST_OUT: begin
                    // No reads here, so the RegisterFile latches hold still.
                    bus.out_valid = 1'b1;
                    bus.out_op_a  = (nsrc_q >= 2'd1) ? bus.rf_latch_1 : '0;
                    bus.out_op_b  = (nsrc_q >= 2'd2) ? bus.rf_latch_2 : '0;
                    bus.out_tag   = tag_q;
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and held-instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            nsrc_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            nsrc_q  <= nsrc_d;
            tag_q   <= tag_d;
        end
    end

endmodule
